// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the FIFO reader-side stream adapter.
package fifo_rd_pkg;
  localparam int RD_LAT_FWFT = 0;
  localparam int RD_LAT_REG  = 1;
  localparam int BUF_DEPTH   = 2;

  typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry circular output buffer presenting a valid/ready stream.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_n,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [width-1:0] out_data,
  output logic             drain,
  output occ_t             occ
);

  logic [width-1:0] mem [BUF_DEPTH];
  logic             head;
  logic             tail;

  assign out_valid = (occ != 2'd0);
  assign drain     = out_valid & out_ready;
  // Output comes straight from storage so fifo_data never reaches out_data combinationally.
  assign out_data  = mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= 2'd0;
    end else if (!init_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_data;
        tail      <= ~tail;
      end
      if (drain) head <= ~head;
      case ({wr_en, drain})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Reader adapter: issues FIFO pops, tracks in-flight words and counts delivered words.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int width      = 8,
  parameter int rd_latency = 0,
  parameter int cnt_width  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_n,
  input  logic                 fifo_empty,
  input  logic [width-1:0]     fifo_data,
  output logic                 fifo_pop_n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width-1:0]     out_data,
  output logic [1:0]           buf_cnt,
  output logic [cnt_width-1:0] words_out
);

  logic       pop;
  logic       inflight;
  logic       drain;
  logic       wr_en;
  logic [2:0] pending;
  occ_t       occ;

  // Slots committed after this edge; at most 2 exist, so pop only when one is left free.
  assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, drain};
  assign pop        = ~rst & init_n & ~fifo_empty & (pending < 3'd2);
  assign fifo_pop_n = ~pop;
  assign buf_cnt    = occ;

  if (rd_latency == RD_LAT_REG) begin : g_reg
    // pop is low while init_n=0, which discards any word in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) inflight <= 1'b0;
      else     inflight <= pop;
    end
    assign wr_en = inflight & init_n;
  end else begin : g_fwft
    assign inflight = 1'b0;
    assign wr_en    = pop;
  end

  fifo_rd_skid #(.width(width)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .init_n    (init_n),
    .wr_en     (wr_en),
    .wr_data   (fifo_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .drain     (drain),
    .occ       (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         words_out <= '0;
    else if (!init_n) words_out <= '0;
    else if (drain)   words_out <= words_out + 1'b1;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: three adapters (FWFT, registered-read, 4-bit counter) fed by simple FIFO models.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  logic rst;
  logic init_n;

  logic [2:0]       fe, pn, ov, ord;
  logic [2:0][7:0]  fd, od;
  logic [2:0][1:0]  bc;
  logic [2:0][15:0] wo;

  logic [7:0] mem [3][256];
  logic [7:0] wr_ptr [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 1 : 0;
    localparam int CW  = (g == 2) ? 4 : 16;
    logic [CW-1:0] w;
    logic [7:0]    rdp = 8'd0;
    logic [7:0]    dreg = 8'd0;

    fifo_rd_stream #(.width(8), .rd_latency(LAT), .cnt_width(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .init_n     (init_n),
      .fifo_empty (fe[g]),
      .fifo_data  (fd[g]),
      .fifo_pop_n (pn[g]),
      .out_valid  (ov[g]),
      .out_ready  (ord[g]),
      .out_data   (od[g]),
      .buf_cnt    (bc[g]),
      .words_out  (w)
    );

    assign wo[g] = 16'(w);
    assign fe[g] = (rdp == wr_ptr[g]);

    always @(posedge clk) begin
      if (!pn[g] && !fe[g]) begin
        dreg <= mem[g][rdp];
        rdp  <= rdp + 8'd1;
      end
    end

    if (LAT == 1) begin : g_l1
      assign fd[g] = dreg;
    end else begin : g_l0
      assign fd[g] = mem[g][rdp];
    end
  end

  typedef struct {
    logic       rdy;
    logic       pop_n;
    logic       valid;
    logic [7:0] data;
    logic [1:0] bc;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int g, input logic [7:0] v);
    mem[g][wr_ptr[g]] = v;
    wr_ptr[g] = wr_ptr[g] + 8'd1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    for (int g = 0; g < 3; g++) wr_ptr[g] = 8'd0;
    rst    = 1'b1;
    init_n = 1'b1;
    ord    = 3'b000;

    // test 1 rows (dut0, FWFT, A1 B2 C3 preloaded)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'hA1, 2'd1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'hB2, 2'd1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'hC3, 2'd1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    // test 3/4 rows (dut0, 30..34, backpressure then release)
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h30, 2'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h30, 2'd2};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h30, 2'd2};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h30, 2'd2};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h31, 2'd2};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h32, 2'd2};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h33, 2'd2};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 8'h34, 2'd1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0};

    repeat (3) next_cycle();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_pop_n", 32'(pn[g]), 32'd1);
      check("rst_valid", 32'(ov[g]), 32'd0);
      check("rst_data",  32'(od[g]), 32'd0);
      check("rst_bc",    32'(bc[g]), 32'd0);
      check("rst_words", 32'(wo[g]), 32'd0);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // test 1
    push(0, 8'hA1); push(0, 8'hB2); push(0, 8'hC3);
    for (int r = 0; r < 5; r++) begin
      ord[0] = tbl[r].rdy;
      @(negedge clk);
      check("t1_pop_n", 32'(pn[0]), 32'(tbl[r].pop_n));
      check("t1_valid", 32'(ov[0]), 32'(tbl[r].valid));
      check("t1_bc",    32'(bc[0]), 32'(tbl[r].bc));
      if (tbl[r].valid) check("t1_data", 32'(od[0]), 32'(tbl[r].data));
      next_cycle();
    end
    check("t1_words", 32'(wo[0]), 32'd3);

    // tests 3 and 4
    for (int i = 0; i < 5; i++) push(0, 8'h30 + 8'(i));
    for (int r = 5; r < 15; r++) begin
      ord[0] = tbl[r].rdy;
      @(negedge clk);
      check("t3_pop_n", 32'(pn[0]), 32'(tbl[r].pop_n));
      check("t3_valid", 32'(ov[0]), 32'(tbl[r].valid));
      check("t3_bc",    32'(bc[0]), 32'(tbl[r].bc));
      if (tbl[r].valid) check("t3_data", 32'(od[0]), 32'(tbl[r].data));
      next_cycle();
    end
    check("t3_words", 32'(wo[0]), 32'd8);

    // test 2: registered-read FIFO, 8 words
    ord[1] = 1'b1;
    for (int i = 0; i < 8; i++) push(1, 8'h10 + 8'(i));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("t2_pop_n", 32'(pn[1]), (c <= 7) ? 32'd0 : 32'd1);
      check("t2_valid", 32'(ov[1]), (c >= 2 && c <= 9) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 9) check("t2_data", 32'(od[1]), 32'h10 + 32'(c - 2));
      next_cycle();
    end
    check("t2_words", 32'(wo[1]), 32'd8);

    // test 5: init_n pulse discards the in-flight word
    push(1, 8'h55); push(1, 8'h66);
    @(negedge clk);
    check("t5_pop", 32'(pn[1]), 32'd0);
    next_cycle();
    init_n = 1'b0;
    @(negedge clk);
    check("t5_pop_forced", 32'(pn[1]), 32'd1);
    next_cycle();
    init_n = 1'b1;
    @(negedge clk);
    check("t5_bc",    32'(bc[1]), 32'd0);
    check("t5_valid", 32'(ov[1]), 32'd0);
    check("t5_words", 32'(wo[1]), 32'd0);
    check("t5_pop2",  32'(pn[1]), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t5_valid_gap", 32'(ov[1]), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t5_valid_next", 32'(ov[1]), 32'd1);
    check("t5_data_next",  32'(od[1]), 32'h66);
    next_cycle();
    check("t5_words_next", 32'(wo[1]), 32'd1);

    // test 6a: async reset with a full buffer
    ord[0] = 1'b0;
    push(0, 8'h77); push(0, 8'h88); push(0, 8'h99);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("t6_bc_full", 32'(bc[0]), 32'd2);
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    check("t6_pop_n", 32'(pn[0]), 32'd1);
    check("t6_valid", 32'(ov[0]), 32'd0);
    check("t6_data",  32'(od[0]), 32'd0);
    check("t6_bc",    32'(bc[0]), 32'd0);
    check("t6_words", 32'(wo[0]), 32'd0);
    next_cycle();
    rst = 1'b0;
    ord[0] = 1'b1;
    @(negedge clk);
    check("t6_pop_after", 32'(pn[0]), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t6_valid_after", 32'(ov[0]), 32'd1);
    check("t6_data_after",  32'(od[0]), 32'h99);
    next_cycle();

    // test 6b: 17 words through the 4-bit counter instance
    ord[2] = 1'b1;
    for (int i = 0; i < 17; i++) push(2, 8'h40 + 8'(i));
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ov[2] && ord[2]) begin
        check("t6b_data", 32'(od[2]), 32'h40 + 32'(idx));
        idx++;
      end
      next_cycle();
    end
    check("t6b_count", 32'(idx), 32'd17);
    check("t6b_wrap",  32'(wo[2]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
